cs_out_buffer: RTL and testbench



---
 rtl/cs_out_buffer.sv | 100 ++++++++++
 tb/tb_cs_out_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cs_out_buffer.sv
// cs_out_buffer: first-word-fall-through output FIFO behind the CS filter.
// Captures valid Y results, hands them to the consumer over valid/ready,
// and never back-pressures the filter: results arriving while full are
// dropped and recorded in a sticky flag and a saturating drop counter.
module cs_out_buffer #(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] y_in,
  input  logic          y_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  input  logic          clr_ovf
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [7:0]  CNT_MAX    = 8'hFF;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic pop, push, drop;

  // Status decode and the forced-zero head so an empty FIFO never shows stale data.
  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = y_valid && (!full || pop);
  assign drop = y_valid && full && !pop;

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      level_d = level_q + (AW + 1)'(1);
    else if (pop && !push) level_d = level_q - (AW + 1)'(1);

    if (clr_ovf) begin
      // A drop coinciding with the clear is counted after the clear.
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; level and pointers define what is valid.
    if (push && !reset) mem_q[wr_ptr_q] <= y_in;
  end

endmodule

// File: tb/tb_cs_out_buffer.sv
// tb_cs_out_buffer: directed stimulus for cs_out_buffer with a scoreboard.
// The stimulus pushes each result it expects to be accepted into a queue;
// an independent monitor pops and compares on every handshake.
module tb_cs_out_buffer;

  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] y_in;
  logic          y_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];

  cs_out_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; the next call's edge samples them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [DW-1:0] v);
    y_in    = v;
    y_valid = 1'b1;
    sb.push_back(v);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    y_valid   = 1'b0;
    out_ready = 1'b1;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    check("drain_empty", {31'd0, empty}, 32'd1);
    out_ready = 1'b0;
  endtask

  // Monitor: on each handshake the head must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid && out_ready && !reset) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got 0x%0h, expected no output", out_data);
      end else begin
        logic [DW-1:0] exp_v;
        exp_v = sb.pop_front();
        check("out_data", {22'd0, out_data}, {22'd0, exp_v});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; y_in = '0; y_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_level",    {28'd0, level},    32'd0);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_data",     {22'd0, out_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Ordering and latency: fill with consumer stalled
    for (int i = 1; i <= 8; i++) begin
      push_val(DW'(i));
      if (i == 1) begin
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_data",  {22'd0, out_data},  32'h001);
      end
    end
    y_valid = 1'b0;
    check("fill_full",  {31'd0, full},  32'd1);
    check("fill_level", {28'd0, level}, 32'd8);
    check("fill_head",  {22'd0, out_data}, 32'h001);
    drain();

    // No bypass: a push into an empty FIFO shows up only after the edge
    out_ready = 1'b1;
    y_in = 10'h0AB; y_valid = 1'b1; sb.push_back(10'h0AB);
    check("nobyp_valid_before", {31'd0, out_valid}, 32'd0);
    tick();
    y_valid = 1'b0;
    check("nobyp_valid_after", {31'd0, out_valid}, 32'd1);
    check("nobyp_data_after",  {22'd0, out_data},  32'h0AB);
    tick();
    check("nobyp_empty", {31'd0, empty}, 32'd1);
    out_ready = 1'b0;

    // Wrap-around with the consumer toggling
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 0);
      push_val(DW'(10'h100 + i));
    end
    y_valid = 1'b0;
    check("wrap_overflow", {31'd0, overflow}, 32'd0);
    drain();

    // Overflow: fill, then three results with nowhere to go
    for (int i = 0; i < 8; i++) push_val(DW'(10'h020 + i));
    y_in = 10'h3FF; y_valid = 1'b1;
    tick(); tick(); tick();
    y_valid = 1'b0;
    check("ovf_flag",  {31'd0, overflow}, 32'd1);
    check("ovf_count", {24'd0, drop_cnt}, 32'd3);
    check("ovf_head",  {22'd0, out_data}, 32'h020);
    check("ovf_level", {28'd0, level},    32'd8);

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    push_val(10'h2AA);
    y_valid = 1'b0; out_ready = 1'b0;
    check("pp_level", {28'd0, level},    32'd8);
    check("pp_full",  {31'd0, full},     32'd1);
    check("pp_drops", {24'd0, drop_cnt}, 32'd3);
    drain();

    // Saturation of the drop counter, then clear with and without a drop
    for (int i = 0; i < 8; i++) push_val(DW'(10'h040 + i));
    y_in = 10'h155; y_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("sat_count", {24'd0, drop_cnt}, 32'd255);
    check("sat_flag",  {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    check("clr_drop_flag",  {31'd0, overflow}, 32'd1);
    check("clr_drop_count", {24'd0, drop_cnt}, 32'd1);
    y_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check("clr_flag",  {31'd0, overflow}, 32'd0);
    check("clr_count", {24'd0, drop_cnt}, 32'd0);
    check("clr_level", {28'd0, level},    32'd8);
    check("clr_head",  {22'd0, out_data}, 32'h040);

    // Reset mid-stream with five stored entries and competing inputs
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    check("mid_level", {28'd0, level}, 32'd5);
    reset = 1'b1; y_in = 10'h3C3; y_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    reset = 1'b0; y_valid = 1'b0; clr_ovf = 1'b0;
    sb.delete();
    check("mrst_level", {28'd0, level},     32'd0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_data",  {22'd0, out_data},  32'd0);
    check("mrst_empty", {31'd0, empty},     32'd1);

    tick(); tick();
    check("sb_left", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
